// File: rtl/vga_pattern_pkg.sv
// Shared constants for the VGA test-pattern engine: pattern modes and
// the width of the frame-rate prescaler derived from the speed field.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CHECKER  = 2'd0,
    MODE_SCROLL   = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  localparam int SPEED_BITS = 2;
  // Largest prescale window is 2^(2^SPEED_BITS - 1) frames; presc counts up to that minus one.
  localparam int PRESC_BITS = (1 << SPEED_BITS) - 1;

endpackage

// File: rtl/vga_frame_stepper.sv
// Frame tick detection (rising edge of vsync) plus a prescaled, pausable
// up/down scroll counter that advances once every 2^speed frames.
module vga_frame_stepper
  import vga_pattern_pkg::*;
#(
  parameter int COUNT_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync_in,
  input  logic [SPEED_BITS-1:0] speed,
  input  logic                  pause,
  input  logic                  reverse,
  output logic                  tick,
  output logic [COUNT_BITS-1:0] count
);

  logic                  vsync_d;
  logic [PRESC_BITS-1:0] presc;
  logic [PRESC_BITS-1:0] presc_max;

  assign tick = vsync_in & ~vsync_d;

  always_comb begin
    presc_max = PRESC_BITS'((32'd1 << speed) - 32'd1);
  end

  // vsync_d resets high so a vsync already high at release is not a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d <= 1'b1;
      presc   <= '0;
      count   <= '0;
    end else begin
      vsync_d <= vsync_in;
      if (tick && !pause) begin
        // >= lets a shrinking speed close the current window immediately.
        if (presc >= presc_max) begin
          presc <= '0;
          count <= reverse ? (count - COUNT_BITS'(1)) : (count + COUNT_BITS'(1));
        end else begin
          presc <= presc + PRESC_BITS'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_engine.sv
// Frame-synchronous VGA test-pattern generator: shadows config on vsync rise,
// computes one of four patterns and registers colour together with the syncs.
module vga_pattern_engine
  import vga_pattern_pkg::*;
#(
  parameter int COLOR_BITS   = 2,
  parameter int COORD_BITS   = 10,
  parameter int COUNT_BITS   = 10,
  parameter int TILE_SHIFT   = 5,
  parameter int SCROLL_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COORD_BITS-1:0]   pix_x,
  input  logic [COORD_BITS-1:0]   pix_y,
  input  logic                    display_on,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic [1:0]              mode,
  input  logic [SPEED_BITS-1:0]   speed,
  input  logic                    pause,
  input  logic                    reverse,
  input  logic [3*COLOR_BITS-1:0] solid_rgb,
  output logic [COLOR_BITS-1:0]   r,
  output logic [COLOR_BITS-1:0]   g,
  output logic [COLOR_BITS-1:0]   b,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic [COUNT_BITS-1:0]   frame_count
);

  localparam int RGB_BITS = 3 * COLOR_BITS;
  localparam int S = SCROLL_SHIFT;
  localparam int T = TILE_SHIFT;

  logic                  tick;
  mode_e                 mode_s;
  logic [SPEED_BITS-1:0] speed_s;
  logic                  pause_s;
  logic                  reverse_s;
  logic [RGB_BITS-1:0]   solid_s;

  logic [SPEED_BITS-1:0] speed_eff;
  logic                  pause_eff;
  logic                  reverse_eff;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_s    <= MODE_CHECKER;
      speed_s   <= '0;
      pause_s   <= 1'b0;
      reverse_s <= 1'b0;
      solid_s   <= '0;
    end else if (tick) begin
      mode_s    <= mode_e'(mode);
      speed_s   <= speed;
      pause_s   <= pause;
      reverse_s <= reverse;
      solid_s   <= solid_rgb;
    end
  end

  // The stepper acts only on tick, where it must see the config being captured.
  assign speed_eff   = tick ? speed   : speed_s;
  assign pause_eff   = tick ? pause   : pause_s;
  assign reverse_eff = tick ? reverse : reverse_s;

  vga_frame_stepper #(
    .COUNT_BITS(COUNT_BITS)
  ) u_stepper (
    .clk      (clk),
    .reset    (reset),
    .vsync_in (vsync_in),
    .speed    (speed_eff),
    .pause    (pause_eff),
    .reverse  (reverse_eff),
    .tick     (tick),
    .count    (frame_count)
  );

  logic [COORD_BITS-1:0] c;

  generate
    if (COUNT_BITS >= COORD_BITS) begin : g_c_trunc
      assign c = frame_count[COORD_BITS-1:0];
    end else begin : g_c_ext
      assign c = {{(COORD_BITS-COUNT_BITS){1'b0}}, frame_count};
    end
  endgenerate

  logic [COORD_BITS-1:0] mx;
  logic [COORD_BITS-1:0] my;
  logic [COORD_BITS-1:0] ix;
  logic [COORD_BITS-1:0] iy;
  logic                  unused_coord_bits;

  assign mx = pix_x + c;
  assign my = pix_y + c;
  assign ix = pix_x - c;
  assign iy = pix_y - c;
  assign unused_coord_bits = ^{mx, my, ix, iy};

  logic                  chk_t;
  logic                  scr_lo;
  logic [COLOR_BITS-1:0] grad_r;
  logic [COLOR_BITS-1:0] grad_g;

  assign chk_t  = mx[T] ^ pix_y[T];
  assign scr_lo = pix_x[T] ^ pix_y[T];
  assign grad_r = mx[S -: COLOR_BITS];
  assign grad_g = pix_y[S -: COLOR_BITS];

  logic [COLOR_BITS-1:0] r_p;
  logic [COLOR_BITS-1:0] g_p;
  logic [COLOR_BITS-1:0] b_p;

  always_comb begin
    r_p = '0;
    g_p = '0;
    b_p = '0;
    case (mode_s)
      MODE_CHECKER: begin
        r_p = {COLOR_BITS{chk_t}};
        g_p = {COLOR_BITS{chk_t}};
        b_p = {COLOR_BITS{chk_t}};
      end
      MODE_SCROLL: begin
        // Low bits carry a static tile pattern; only the MSB scrolls.
        r_p = {COLOR_BITS{scr_lo}};
        g_p = {COLOR_BITS{scr_lo}};
        b_p = {COLOR_BITS{scr_lo}};
        r_p[COLOR_BITS-1] = ix[S] ^ mx[S];
        g_p[COLOR_BITS-1] = mx[S] ^ my[S];
        b_p[COLOR_BITS-1] = mx[S] ^ iy[S];
      end
      MODE_GRADIENT: begin
        r_p = grad_r;
        g_p = grad_g;
        b_p = grad_r ^ grad_g;
      end
      MODE_SOLID: begin
        r_p = solid_s[RGB_BITS-1 -: COLOR_BITS];
        g_p = solid_s[2*COLOR_BITS-1 -: COLOR_BITS];
        b_p = solid_s[COLOR_BITS-1:0];
      end
      default: begin
        r_p = '0;
        g_p = '0;
        b_p = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      r         <= display_on ? r_p : '0;
      g         <= display_on ? g_p : '0;
      b         <= display_on ? b_p : '0;
    end
  end

endmodule
